// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared opcode/funct constants, FSM states and control encodings
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [2:0] ALUOP_NONE = 3'b000;
  localparam logic [2:0] ALUOP_ADD  = 3'b001;
  localparam logic [2:0] ALUOP_SUB  = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef enum logic [4:0] {
    FETCH0      = 5'd0,
    FETCH1      = 5'd1,
    FETCH2      = 5'd2,
    DECODE      = 5'd3,
    EXEC_R      = 5'd4,
    WB_R        = 5'd5,
    EXEC_I      = 5'd6,
    WB_I        = 5'd7,
    MEM_ADDR    = 5'd8,
    MEM_RD      = 5'd9,
    MEM_RD_WAIT = 5'd10,
    WB_LW       = 5'd11,
    MEM_WR      = 5'd12,
    BRANCH      = 5'd13,
    JUMP        = 5'd14,
    EXC_EPC     = 5'd15,
    EXC_VEC     = 5'd16
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       epc_write;
    logic       exc_cause;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);

  function automatic logic is_alu_funct(input logic [5:0] f);
    return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND);
  endfunction

  function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
    case (f)
      FUNCT_ADD: return ALUOP_ADD;
      FUNCT_SUB: return ALUOP_SUB;
      FUNCT_AND: return ALUOP_AND;
      default:   return ALUOP_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_output_decode.sv
// ============================================================================
// ctrl_output_decode : Moore decode of FSM state (+ latched funct/cause) into
//                      the datapath control word
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]        state,
  input  logic [5:0]        funct_q,
  input  logic              cause_q,
  output logic [CTRL_W-1:0] ctrl_word
);

  state_e     st;
  ctrl_word_t cw;

  assign st = state_e'(state);

  always_comb begin
    cw = '0;
    case (st)
      FETCH0: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
        cw.pc_write  = 1'b1;
      end
      FETCH1:  cw.mem_read = 1'b1;
      FETCH2:  cw.ir_write = 1'b1;
      DECODE: begin
        // Speculative branch target: PC + (imm << 2)
        cw.alu_src_b = SRCB_IMM_SH2;
        cw.alu_op    = ALUOP_ADD;
      end
      EXEC_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_B;
        cw.alu_op    = funct_alu_op(funct_q);
      end
      WB_R: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      WB_I:    cw.reg_write = 1'b1;
      MEM_RD, MEM_RD_WAIT: begin
        cw.iord     = 1'b1;
        cw.mem_read = 1'b1;
      end
      WB_LW: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      MEM_WR: begin
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
      end
      BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_B;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_source     = PCSRC_ALUOUT;
        cw.pc_write_cond = 1'b1;
      end
      JUMP: begin
        cw.pc_source = PCSRC_JUMP;
        cw.pc_write  = 1'b1;
      end
      EXC_EPC: begin
        // PC was already incremented in FETCH0; EPC gets PC - 4
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_SUB;
        cw.epc_write = 1'b1;
        cw.exc_cause = cause_q;
      end
      EXC_VEC: begin
        cw.pc_source = PCSRC_EXC;
        cw.pc_write  = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  assign ctrl_word = cw;

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multicycle MIPS-subset control FSM with memory wait counter
// Build option    : OVERFLOW_EXC_EN turns ALU overflow into an exception
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic       EPCWrite,
  output logic       ExcCause,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [4:0] state_dbg
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [5:0]        funct_q, funct_d;
  logic              ovf_q, ovf_d;
  logic              cause_q, cause_d;
  logic [CTRL_W-1:0] ctrl_raw;
  ctrl_word_t        ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH0;
      cnt_q   <= 2'd0;
      funct_q <= 6'd0;
      ovf_q   <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      funct_q <= funct_d;
      ovf_q   <= ovf_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    funct_d = funct_q;
    ovf_d   = ovf_q;
    cause_d = cause_q;
    case (state_q)
      FETCH0: begin
        state_d = FETCH1;
        cnt_d   = 2'd0;
      end
      FETCH1: begin
        if (cnt_q == LAT_LAST) begin
          state_d = FETCH2;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      FETCH2: state_d = DECODE;
      DECODE: begin
        // funct captured here so EXEC_R's ALUOp comes from a register
        funct_d = funct;
        cause_d = 1'b0;
        case (opcode)
          OP_RTYPE:      state_d = is_alu_funct(funct) ? EXEC_R : EXC_EPC;
          OP_ADDI:       state_d = EXEC_I;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          default:       state_d = EXC_EPC;
        endcase
      end
      EXEC_R: begin
        ovf_d   = overflow;
        state_d = WB_R;
`ifdef OVERFLOW_EXC_EN
        if (overflow && (funct_q != FUNCT_AND)) begin
          state_d = EXC_EPC;
          cause_d = 1'b1;
        end
`endif
      end
      EXEC_I: begin
        ovf_d   = overflow;
        state_d = WB_I;
`ifdef OVERFLOW_EXC_EN
        if (overflow) begin
          state_d = EXC_EPC;
          cause_d = 1'b1;
        end
`endif
      end
      MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        state_d = MEM_RD_WAIT;
        cnt_d   = 2'd0;
      end
      MEM_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = WB_LW;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WB_R, WB_I, WB_LW, MEM_WR, BRANCH, JUMP, EXC_VEC: state_d = FETCH0;
      EXC_EPC: state_d = EXC_VEC;
      default: state_d = FETCH0;
    endcase
  end

  ctrl_output_decode u_decode (
    .state     (state_q),
    .funct_q   (funct_q),
    .cause_q   (cause_q),
    .ctrl_word (ctrl_raw)
  );

  // Reset masks the whole word so a write in flight never commits
  assign ctrl      = reset ? '0 : ctrl_word_t'(ctrl_raw);
  assign state_dbg = reset ? 5'd0 : state_q;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemToReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign EPCWrite    = ctrl.epc_write;
  assign ExcCause    = ctrl.exc_cause;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

  // zero is consumed by the datapath through PCWriteCond; ovf_q is debug state
  logic unused_sink;
  assign unused_sink = ^{zero, ovf_q};

endmodule

`default_nettype wire
